// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between two requesters; each access
// runs IDLE -> ISSUE -> RESP, and every output comes straight from a register.
module regfile_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t              state_r;
    logic                prio_r;
    logic                win_r;
    logic                op_we_r;
    logic                gnt0_r;
    logic                gnt1_r;
    logic                rsp_valid0_r;
    logic                rsp_valid1_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                rf_we_r;
    logic [ADDR_W-1:0]   rf_write_addr_r;
    logic [DATA_W-1:0]   rf_write_data_r;
    logic [ADDR_W-1:0]   rf_read_addr_r;

    logic                win_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    // Winner selection: a lone requester wins, a tie goes to the requester named by prio.
    always_comb begin
        win_s = 1'b0;
        if (req0 && req1) begin
            win_s = prio_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        sel_we_s    = we0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        if (win_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Access sequencer; the rf address/data registers double as the latched operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            prio_r          <= 1'b0;
            win_r           <= 1'b0;
            op_we_r         <= 1'b0;
            gnt0_r          <= 1'b0;
            gnt1_r          <= 1'b0;
            rsp_valid0_r    <= 1'b0;
            rsp_valid1_r    <= 1'b0;
            rsp_rdata_r     <= {DATA_W{1'b0}};
            rf_we_r         <= 1'b0;
            rf_write_addr_r <= {ADDR_W{1'b0}};
            rf_write_data_r <= {DATA_W{1'b0}};
            rf_read_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state_r         <= ST_ISSUE;
                        win_r           <= win_s;
                        prio_r          <= ~win_s;
                        op_we_r         <= sel_we_s;
                        gnt0_r          <= ~win_s;
                        gnt1_r          <= win_s;
                        rf_we_r         <= sel_we_s;
                        rf_write_addr_r <= sel_addr_s;
                        rf_read_addr_r  <= sel_addr_s;
                        rf_write_data_r <= sel_wdata_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r      <= ST_RESP;
                    gnt0_r       <= 1'b0;
                    gnt1_r       <= 1'b0;
                    rf_we_r      <= 1'b0;
                    rsp_valid0_r <= ~win_r;
                    rsp_valid1_r <= win_r;
                    // Writes leave the shared read data untouched.
                    if (!op_we_r) begin
                        rsp_rdata_r <= rf_read_data;
                    end else begin
                        rsp_rdata_r <= rsp_rdata_r;
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    rsp_valid0_r <= 1'b0;
                    rsp_valid1_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    gnt0_r       <= 1'b0;
                    gnt1_r       <= 1'b0;
                    rsp_valid0_r <= 1'b0;
                    rsp_valid1_r <= 1'b0;
                    rf_we_r      <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0          = gnt0_r;
    assign gnt1          = gnt1_r;
    assign rsp_valid0    = rsp_valid0_r;
    assign rsp_valid1    = rsp_valid1_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rf_we         = rf_we_r;
    assign rf_write_addr = rf_write_addr_r;
    assign rf_write_data = rf_write_data_r;
    assign rf_read_addr  = rf_read_addr_r;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a register file stand-in, a transaction-level
// reference model checked every cycle, and hand-computed expectations per scenario.
module tb_regfile_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rsp_valid0, rsp_valid1, rf_we;
    logic [DATA_W-1:0] rsp_rdata, rf_write_data, rf_read_data;
    logic [ADDR_W-1:0] rf_write_addr, rf_read_addr;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    regfile_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_rdata(rsp_rdata), .rf_we(rf_we), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    // Register file stand-in: synchronous write, combinational read.
    logic [DATA_W-1:0] rf_mem [8] = '{default: 8'h00};
    always @(posedge clk) if (rf_we) rf_mem[rf_write_addr] <= rf_write_data;
    assign rf_read_data = rf_mem[rf_read_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles since the last grant, a shadow memory and the round-robin pointer.
    int                m_phase;
    logic              m_win, m_we, m_prio;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic [DATA_W-1:0] m_mem [8] = '{default: 8'h00};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_win = 1'b0; m_we = 1'b0; m_prio = 1'b0;
            m_addr = 3'd0; m_wdata = 8'h00; m_rdata = 8'h00;
        end else if (m_phase == 0) begin
            if (req0 || req1) begin
                m_win   = (req0 && req1) ? m_prio : req1;
                m_prio  = !m_win;
                m_we    = m_win ? we1 : we0;
                m_addr  = m_win ? addr1 : addr0;
                m_wdata = m_win ? wdata1 : wdata0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_we) m_mem[m_addr] = m_wdata;
            else m_rdata = m_mem[m_addr];
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gnt0", gnt0, m_phase == 1 && !m_win);
            chk("gnt1", gnt1, m_phase == 1 && m_win);
            chk("rsp_valid0", rsp_valid0, m_phase == 2 && !m_win);
            chk("rsp_valid1", rsp_valid1, m_phase == 2 && m_win);
            chk("rf_we", rf_we, m_phase == 1 && m_we);
            chk("rf_write_addr", rf_write_addr, m_addr);
            chk("rf_read_addr", rf_read_addr, m_addr);
            chk("rf_write_data", rf_write_data, m_wdata);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_excl", rsp_valid0 & rsp_valid1, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_any(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            tick();
            if (gnt0 || gnt1) ok = 1'b1;
        end
        chk("grant_timeout", ok, 1'b1);
    endtask

    task automatic do_req(input logic id, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd);
        logic ok;
        if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        wait_any(ok);
        chk("grant_owner", id ? gnt1 : gnt0, 1'b1);
        chk("issue_rf_we", rf_we, we);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        tick();
        chk("resp_owner", id ? rsp_valid1 : rsp_valid0, 1'b1);
        rd = rsp_rdata;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] rd;
        logic ok;
        logic g;
        req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 3'd0; addr1 = 3'd0; wdata0 = 8'h00; wdata1 = 8'h00;
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        // 1: reset held with a pending request, then first grant goes to req0
        repeat (3) tick();
        chk("t1_gnt0_in_reset", gnt0, 1'b0);
        chk("t1_rf_we_in_reset", rf_we, 1'b0);
        rst = 1'b1;
        do_req(1'b0, 1'b0, 3'd0, 8'h00, rd);
        chk("t1_read0", rd, 8'h00);

        // 2: single write then read back
        do_req(1'b0, 1'b1, 3'd1, 8'hA5, rd);
        do_req(1'b0, 1'b0, 3'd1, 8'h00, rd);
        chk("t2_readback", rd, 8'hA5);

        // 3: continuous contention from a fresh priority pointer
        rst = 1'b0; tick(); rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            wait_any(ok);
            g = gnt1;
            chk("t3_grant_order", g, k % 2);
            tick();
            if (k == 0) chk("t3_read_before_write", rsp_rdata, 8'h00);
            if (k == 2) chk("t3_read_after_write", rsp_rdata, 8'h5A);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

        // 4: read on one requester right after a write from the other
        do_req(1'b1, 1'b1, 3'd7, 8'h3C, rd);
        do_req(1'b0, 1'b0, 3'd7, 8'h00, rd);
        chk("t4_read_after_write", rd, 8'h3C);

        // 5: reset lands during ISSUE of a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd4; wdata0 = 8'hFF;
        wait_any(ok);
        chk("t5_rf_we_issue", rf_we, 1'b1);
        rst = 1'b0;
        #1;
        chk("t5_rf_we_dropped", rf_we, 1'b0);
        chk("t5_gnt0_dropped", gnt0, 1'b0);
        req0 = 1'b0;
        tick(); tick();
        chk("t5_no_rsp", rsp_valid0 | rsp_valid1, 1'b0);
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd4;
        req1 = 1'b1; we1 = 1'b0; addr1 = 3'd4;
        wait_any(ok);
        chk("t5_prio_reset", gnt0, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("t5_rsp0", rsp_valid0, 1'b1);
        chk("t5_write_abandoned", rsp_rdata, 8'h00);
        tick();

        // 6: idle gap keeps everything quiet and read data stable
        do_req(1'b0, 1'b0, 3'd7, 8'h00, rd);
        chk("t6_read", rd, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_rf_we", rf_we, 1'b0);
            chk("t6_gnt", gnt0 | gnt1, 1'b0);
            chk("t6_rsp", rsp_valid0 | rsp_valid1, 1'b0);
            chk("t6_rdata", rsp_rdata, 8'h3C);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
